// File: rtl/serial_mag_comp.sv
// serial_mag_comp: digit-serial MSB-first magnitude comparator, signed or unsigned per request,
// with START/BUSY/DONE handshake and optional early exit at the first differing digit.
module serial_mag_comp #(
   parameter int WIDTH      = 16,
   parameter int DIGIT      = 4,
   parameter int EARLY_EXIT = 1,
   localparam int NDIG      = WIDTH / DIGIT,
   localparam int CW        = $clog2(NDIG + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_signed,
   input  logic [WIDTH-1:0] i_x,
   input  logic [WIDTH-1:0] i_y,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_lg_out,
   output logic             o_eq_out,
   output logic             o_rg_out,
   output logic [CW-1:0]    o_cycles
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
   state_t r_state, w_next;
   logic [WIDTH-1:0] r_x, r_y, w_flip;
   logic [DIGIT-1:0] w_dx, w_dy;
   logic [CW-1:0] r_cnt, r_cycles;
   logic r_gt, r_lt, r_lg, r_eq, r_rg;
   logic w_gt, w_lt, w_last, w_decide, w_cap;
   // Flipping the sign bit maps two's complement onto offset binary, so one unsigned scan serves both modes.
   assign w_flip   = WIDTH'(i_signed) << (WIDTH - 1);
   assign w_dx     = r_x[WIDTH-1 -: DIGIT];
   assign w_dy     = r_y[WIDTH-1 -: DIGIT];
   assign w_gt     = r_gt || (!r_lt && w_dx > w_dy);
   assign w_lt     = r_lt || (!r_gt && w_dx < w_dy);
   assign w_last   = r_cnt == CW'(NDIG - 1);
   assign w_decide = w_last || (EARLY_EXIT != 0 && (w_gt || w_lt));
   assign w_cap    = i_start && r_state != S_RUN;
   always_comb begin
      w_next = r_state;
      w_next = (r_state == S_RUN) ? (w_decide ? S_FIN : S_RUN) : (i_start ? S_RUN : S_IDLE);
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_state <= S_IDLE;
      else r_state <= w_next;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_x      <= '0;
         r_y      <= '0;
         r_gt     <= 1'b0;
         r_lt     <= 1'b0;
         r_cnt    <= '0;
         r_lg     <= 1'b0;
         r_eq     <= 1'b0;
         r_rg     <= 1'b0;
         r_cycles <= '0;
      end else if (w_cap) begin
         r_x   <= i_x ^ w_flip;
         r_y   <= i_y ^ w_flip;
         r_gt  <= 1'b0;
         r_lt  <= 1'b0;
         r_cnt <= '0;
      end else if (r_state == S_RUN) begin
         r_x   <= r_x << DIGIT;
         r_y   <= r_y << DIGIT;
         r_gt  <= w_gt;
         r_lt  <= w_lt;
         r_cnt <= r_cnt + CW'(1);
         if (w_decide) begin
            r_lg     <= w_gt;
            r_rg     <= w_lt;
            r_eq     <= !(w_gt || w_lt);
            r_cycles <= r_cnt + CW'(1);
         end
      end
   assign o_busy   = r_state == S_RUN;
   assign o_done   = r_state == S_FIN;
   assign o_lg_out = r_lg;
   assign o_eq_out = r_eq;
   assign o_rg_out = r_rg;
   assign o_cycles = r_cycles;
endmodule

// File: tb/tb_serial_mag_comp.sv
// tb_serial_mag_comp: drives four comparator configurations (16/4 early, 16/4 full scan,
// 16/1 early, 16/16 early) against an arithmetic reference model.
module tb_serial_mag_comp;
   logic clk = 1'b0, rst_n = 1'b0, sgn = 1'b0;
   logic [15:0] x = '0, y = '0;
   logic [3:0] start = '0, busy, done, lg, eq, rg;
   logic [4:0] cyc [4];
   int n_chk = 0, n_fail = 0, ecnt = 0, t0 = 0;
   always #5 clk = ~clk;
   always @(posedge clk) ecnt++;
   function automatic int dig(int g);
      return g == 2 ? 1 : g == 3 ? 16 : 4;
   endfunction
   function automatic int early(int g);
      return g == 1 ? 0 : 1;
   endfunction
   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int D = dig(g);
      localparam int C = $clog2(16 / D + 1);
      logic [C-1:0] w_cyc;
      serial_mag_comp #(.WIDTH(16), .DIGIT(D), .EARLY_EXIT(early(g))) u_dut (
         .i_clk(clk), .i_rst_n(rst_n), .i_start(start[g]), .i_signed(sgn), .i_x(x), .i_y(y),
         .o_busy(busy[g]), .o_done(done[g]), .o_lg_out(lg[g]), .o_eq_out(eq[g]),
         .o_rg_out(rg[g]), .o_cycles(w_cyc));
      assign cyc[g] = 5'(w_cyc);
   end
   // Expected digits examined: position of the highest differing bit decides the digit index.
   function automatic int exp_lat(int g, logic [15:0] a, logic [15:0] b);
      logic [15:0] d;
      int msb;
      d = a ^ b;
      if (early(g) == 0 || d == 0) return 16 / dig(g);
      msb = 0;
      for (int i = 0; i < 16; i++) if (d[i]) msb = i;
      return (15 - msb) / dig(g) + 1;
   endfunction
   function automatic logic [2:0] exp_rel(logic [15:0] a, logic [15:0] b, logic s);
      logic gt;
      gt = s ? ($signed(a) > $signed(b)) : (a > b);
      return {gt, a == b, !gt && a != b};
   endfunction
   task automatic check(string tag, int g, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, g, obs, exp);
      end
   endtask
   task automatic launch(int g, logic [15:0] a, logic [15:0] b, logic s);
      @(negedge clk);
      x = a; y = b; sgn = s; start[g] = 1'b1;
      @(posedge clk);
      #1 start[g] = 1'b0;
      t0 = ecnt;
      check("busy_after_start", g, 32'(busy[g]), 1);
      x = 16'($urandom); y = 16'($urandom); sgn = 1'($urandom);
   endtask
   task automatic finish(int g, logic [15:0] a, logic [15:0] b, logic s);
      int lim;
      lim = ecnt + 40;
      do begin
         @(posedge clk);
         #1;
      end while (!done[g] && ecnt < lim);
      check("latency", g, 32'(ecnt - t0), 32'(exp_lat(g, a, b)));
      check("result", g, {29'd0, lg[g], eq[g], rg[g]}, {29'd0, exp_rel(a, b, s)});
      check("cycles", g, 32'(cyc[g]), 32'(exp_lat(g, a, b)));
   endtask
   task automatic compare(int g, logic [15:0] a, logic [15:0] b, logic s);
      launch(g, a, b, s);
      finish(g, a, b, s);
      @(posedge clk);
      #1 check("done_pulse_end", g, {30'd0, done[g], busy[g]}, 0);
   endtask
   initial begin
      logic [15:0] a, b;
      int any_done;
      #1;
      for (int g = 0; g < 4; g++)
         check("reset_state", g, {22'd0, busy[g], done[g], lg[g], eq[g], rg[g], cyc[g]}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      compare(0, 16'h8000, 16'h7FFF, 1'b0);
      compare(0, 16'h1234, 16'h1234, 1'b0);
      compare(0, 16'hFFFF, 16'h0001, 1'b1);
      compare(0, 16'hFFFF, 16'h0001, 1'b0);
      compare(1, 16'h9000, 16'h1FFF, 1'b0);
      compare(2, 16'h8000, 16'h7FFF, 1'b1);
      compare(2, 16'h0000, 16'h0001, 1'b0);
      compare(3, 16'h1234, 16'h1234, 1'b0);
      compare(3, 16'h7FFF, 16'h8000, 1'b1);
      // START pulse during RUN is ignored; START in the FIN cycle chains a second compare.
      launch(0, 16'h1234, 16'h1234, 1'b0);
      @(negedge clk);
      x = 16'h0000; y = 16'hFFFF; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      finish(0, 16'h1234, 16'h1234, 1'b0);
      launch(0, 16'h0010, 16'h0100, 1'b0);
      check("b2b_done_low", 0, 32'(done[0]), 0);
      check("b2b_result_held", 0, {29'd0, lg[0], eq[0], rg[0]}, 32'b010);
      finish(0, 16'h0010, 16'h0100, 1'b0);
      @(posedge clk);
      #1 check("b2b_idle", 0, {30'd0, done[0], busy[0]}, 0);
      // Asynchronous reset mid-compare aborts without a DONE.
      launch(0, 16'h1234, 16'h1234, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check("abort_outputs", 0, {27'd0, busy[0], done[0], lg[0], eq[0], rg[0]}, 0);
      check("abort_cycles", 0, 32'(cyc[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      any_done = 0;
      repeat (8) begin
         @(posedge clk);
         #1 if (done[0]) any_done = 1;
      end
      check("abort_no_done", 0, 32'(any_done), 0);
      compare(0, 16'h00F0, 16'h00E0, 1'b0);
      for (int g = 0; g < 4; g++)
         for (int k = 0; k < 30; k++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
               0: b = a;
               1: b = a ^ (16'h1 << $urandom_range(0, 15));
               default: b = 16'($urandom);
            endcase
            compare(g, a, b, 1'($urandom_range(0, 1)));
         end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
